nrzi_symbol_encoder: RTL and testbench

- Transmit-side companion to the team's Mealy symbol decoder.
- Accepts parallel data words over a valid/ready handshake and serializes each word into a 2-bit symbol stream the decoder consumes:
  - 2'b10 = SYNC (decoder re-arms, level cleared to 0)
  - 2'b01 = TOGGLE (level inverts)
  - 2'b00 = HOLD (level kept)
- Each word is framed as SYNC_LEN sync symbols followed by DATA_W data symbols, LSB first, NRZI-coded against a tracked line level.

---
 rtl/nrzi_symbol_encoder_if.sv | 30 +++
 rtl/nrzi_symbol_encoder.sv | 158 +++++++++++++++
 tb/tb_nrzi_symbol_encoder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/nrzi_symbol_encoder_if.sv
// Word-in / symbol-out bundle for nrzi_symbol_encoder.
// master drives words into the encoder; slave is the encoder side.
interface nrzi_symbol_encoder_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic [1:0]        sym_out;
    logic              sym_valid;
    logic              frame_done;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  sym_out,
        input  sym_valid,
        input  frame_done
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output sym_out,
        output sym_valid,
        output frame_done
    );
endinterface

// File: rtl/nrzi_symbol_encoder.sv
// Frames each accepted word as SYNC_LEN SYNC symbols plus DATA_W NRZI data symbols (LSB first).
// Define NRZI_ENC_PARITY_EN to append one NRZI-coded even-parity symbol per frame.
module nrzi_symbol_encoder #(
    parameter int SYNC_LEN = 2,
    parameter int DATA_W   = 8
) (
    input logic                    clk,
    input logic                    reset,
    nrzi_symbol_encoder_if.slave   bus
);
    localparam int CNT_MAX = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] SYM_HOLD   = 2'b00;
    localparam logic [1:0] SYM_TOGGLE = 2'b01;
    localparam logic [1:0] SYM_SYNC   = 2'b10;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] DATA   = 2'd2;
`ifdef NRZI_ENC_PARITY_EN
    localparam logic [1:0] PARITY = 2'd3;
    localparam logic       DATA_ENDS_FRAME = 1'b0;
`else
    localparam logic       DATA_ENDS_FRAME = 1'b1;
`endif

    logic [1:0]        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, nc;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              level, level_n;
    logic [1:0]        sym_p0, sym_n;
    logic              vld_p0, vld_n;
    logic              done_p0, done_n;
    logic              final_sym;
    logic              accept;
`ifdef NRZI_ENC_PARITY_EN
    logic              par, par_n;
`endif

    // NRZI: a bit differing from the line level toggles it, an equal bit holds it.
    function automatic logic [1:0] nrzi_sym(input logic b, input logic lvl);
        return (b != lvl) ? SYM_TOGGLE : SYM_HOLD;
    endfunction

`ifdef NRZI_ENC_PARITY_EN
    assign final_sym = (state == PARITY);
`else
    assign final_sym = (state == DATA) && (cnt == DATA_LAST);
`endif

    assign bus.data_ready = (state == IDLE) || final_sym;
    assign accept         = bus.data_valid && bus.data_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        level_n = level;
        sym_n   = SYM_HOLD;
        vld_n   = 1'b0;
        done_n  = 1'b0;
        nc      = cnt + 1'b1;
`ifdef NRZI_ENC_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: ;
            SYNC: begin
                vld_n   = 1'b1;
                level_n = 1'b0;
                if (cnt == SYNC_LAST) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    sym_n   = nrzi_sym(shreg[0], 1'b0);
                    level_n = shreg[0];
                    shreg_n = shreg >> 1;
                    done_n  = DATA_ENDS_FRAME && (DATA_LAST == '0);
                end else begin
                    cnt_n = nc;
                    sym_n = SYM_SYNC;
                end
            end
            DATA: begin
                if (cnt == DATA_LAST) begin
`ifdef NRZI_ENC_PARITY_EN
                    state_n = PARITY;
                    vld_n   = 1'b1;
                    done_n  = 1'b1;
                    sym_n   = nrzi_sym(par, level);
                    level_n = par;
`else
                    state_n = IDLE;
`endif
                end else begin
                    vld_n   = 1'b1;
                    cnt_n   = nc;
                    sym_n   = nrzi_sym(shreg[0], level);
                    level_n = shreg[0];
                    shreg_n = shreg >> 1;
                    done_n  = DATA_ENDS_FRAME && (nc == DATA_LAST);
                end
            end
`ifdef NRZI_ENC_PARITY_EN
            PARITY: state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase

        // Accept only happens in IDLE or on the final symbol, so a new frame overrides the wind-down.
        if (accept) begin
            state_n = SYNC;
            cnt_n   = '0;
            shreg_n = bus.data_in;
            level_n = 1'b0;
            sym_n   = SYM_SYNC;
            vld_n   = 1'b1;
            done_n  = 1'b0;
`ifdef NRZI_ENC_PARITY_EN
            par_n   = ^bus.data_in;
`endif
        end
    end

    // Stage p0: registered line outputs and frame state
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            level   <= 1'b0;
            sym_p0  <= SYM_HOLD;
            vld_p0  <= 1'b0;
            done_p0 <= 1'b0;
`ifdef NRZI_ENC_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            level   <= level_n;
            sym_p0  <= sym_n;
            vld_p0  <= vld_n;
            done_p0 <= done_n;
`ifdef NRZI_ENC_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    assign bus.sym_out    = sym_p0;
    assign bus.sym_valid  = vld_p0;
    assign bus.frame_done = done_p0;
endmodule

// File: tb/tb_nrzi_symbol_encoder.sv
// Scoreboard bench for nrzi_symbol_encoder: a frame model pushes expected symbols on accept,
// a negedge monitor pops and compares every cycle.
module tb_nrzi_symbol_encoder;
    localparam int SYNC_LEN = 2;
    localparam int DATA_W   = 8;

    typedef struct packed {
        logic [1:0] sym;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mon_en = 1'b0;
    logic acc;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    logic [1:0] obs[$];

    nrzi_symbol_encoder_if #(.DATA_W(DATA_W)) bus ();

    nrzi_symbol_encoder #(
        .SYNC_LEN(SYNC_LEN),
        .DATA_W  (DATA_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: SYNC run, then each bit LSB first against a level that starts at 0.
    function automatic void push_frame(input logic [DATA_W-1:0] w);
        logic lvl;
        exp_t e;
        lvl = 1'b0;
        for (int i = 0; i < SYNC_LEN; i++) begin
            e.sym = 2'b10; e.last = 1'b0;
            sb_q.push_back(e);
        end
        for (int i = 0; i < DATA_W; i++) begin
            if (w[i] != lvl) begin
                e.sym = 2'b01; lvl = w[i];
            end else begin
                e.sym = 2'b00;
            end
`ifdef NRZI_ENC_PARITY_EN
            e.last = 1'b0;
`else
            e.last = (i == DATA_W - 1);
`endif
            sb_q.push_back(e);
        end
`ifdef NRZI_ENC_PARITY_EN
        e.sym  = ((^w) != lvl) ? 2'b01 : 2'b00;
        e.last = 1'b1;
        sb_q.push_back(e);
`endif
    endfunction

    // One clock: apply the handshake to the model exactly as the DUT sees it at the edge.
    task automatic tick();
        @(posedge clk);
        acc = 1'b0;
        if (reset) begin
            sb_q.delete();
        end else if (bus.data_valid && sb_q.size() == 0) begin
            push_frame(bus.data_in);
            acc = 1'b1;
        end
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] w, input bit hold);
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (acc) break;
        end
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept of %0h", w);
        end
        if (!hold) bus.data_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb_q.size() != 0; t++) tick();
        if (sb_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
        tick();
        tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("sym_valid", 32'(bus.sym_valid), 32'd1);
                    check("sym_out", 32'(bus.sym_out), 32'(e.sym));
                    check("frame_done", 32'(bus.frame_done), 32'(e.last));
                    check("data_ready_busy", 32'(bus.data_ready), 32'(sb_q.size() == 0));
                    obs.push_back(bus.sym_out);
                end else begin
                    check("idle_sym_valid", 32'(bus.sym_valid), 32'd0);
                    check("idle_sym_out", 32'(bus.sym_out), 32'd0);
                    check("idle_frame_done", 32'(bus.frame_done), 32'd0);
                    check("idle_data_ready", 32'(bus.data_ready), 32'd1);
                end
            end
        end
    end

    initial begin : driver
        logic [1:0] kat[$];
        bus.data_in    = 8'hA5;
        bus.data_valid = 1'b1;
        reset          = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus.data_valid = 1'b0;
        tick();

        // Known-answer frame for 0xA5
        obs.delete();
        send(8'hA5, 1'b0);
        drain();
        kat = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01};
`ifdef NRZI_ENC_PARITY_EN
        kat.push_back(2'b01);
`endif
        check("kat_len", 32'(obs.size()), 32'(kat.size()));
        for (int i = 0; i < kat.size() && i < obs.size(); i++)
            check($sformatf("kat_sym%0d", i), 32'(obs[i]), 32'(kat[i]));

        send(8'h00, 1'b0);
        drain();
        send(8'hFF, 1'b0);
        drain();

        // Back-to-back with valid held
        send(8'hFF, 1'b1);
        send(8'h01, 1'b0);
        drain();

        // Reset on the 5th symbol of a frame
        send(8'hA5, 1'b0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        send(8'hFF, 1'b0);
        drain();

        // Valid held and data_in scrambled while busy
        send(8'h3C, 1'b1);
        for (int t = 0; t < 100; t++) begin
            bus.data_in = DATA_W'($urandom);
            tick();
            if (acc) break;
        end
        bus.data_valid = 1'b0;
        drain();

        // Randomized traffic with gaps and occasional back-to-back
        for (int n = 0; n < 150; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                bus.data_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    bus.data_in = DATA_W'($urandom);
                    tick();
                end
            end
            send(DATA_W'($urandom), bit'($urandom_range(0, 1)));
        end
        bus.data_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
